// File: rtl/cla_adder_pipelined_if.sv
// Operand/result bundle for cla_adder_pipelined; ovf only exists when CLA_ADD_OVF_EN is defined.
// slave = adder side, master = operand source / result consumer side.
interface cla_adder_pipelined_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
`ifdef CLA_ADD_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
`ifdef CLA_ADD_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_adder_pipelined.sv
// Pipelined 4-bit-group CLA add/sub; result STAGES+1 edges after accept, global stall (in_ready = ~out_valid | out_ready).
// Optional signed-overflow output under CLA_ADD_OVF_EN. WIDTH multiple of 4, GRP_PER_STG divides WIDTH/4.
module cla_adder_pipelined #(
  parameter int WIDTH       = 16,
  parameter int GRP_PER_STG = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  cla_adder_pipelined_if.slave bus
);
  localparam int NGRP   = WIDTH / 4;
  localparam int STAGES = NGRP / GRP_PER_STG;

  logic                         w_adv;
  logic [STAGES:0]              r_vld;
  logic [STAGES:0]              r_c;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES:0][WIDTH-1:0]   r_sum;
  logic [STAGES:0][WIDTH-1:0]   w_sum;
  logic [STAGES:0]              w_c;
  logic [3:0]                   w_p;
  logic [3:0]                   w_g;
  logic [4:1]                   w_gc;
  logic                         w_cy;
`ifdef CLA_ADD_OVF_EN
  logic                         w_cmsb;
  logic                         r_ovf;
`endif

  assign w_adv = ~r_vld[STAGES] | bus.out_ready;

  // Stage k resolves its groups from the carry registered by stage k-1; r_sum[0] stays zero.
  always_comb begin
    w_sum = '0;
    w_c   = '0;
    w_p   = '0;
    w_g   = '0;
    w_gc  = '0;
    w_cy  = 1'b0;
`ifdef CLA_ADD_OVF_EN
    w_cmsb = 1'b0;
`endif
    for (int k = 1; k <= STAGES; k++) begin
      w_sum[k] = r_sum[k-1];
      w_cy     = r_c[k-1];
      for (int g = (k-1)*GRP_PER_STG; g < k*GRP_PER_STG; g++) begin
        w_p = r_a[k-1][g*4 +: 4] ^ r_b[k-1][g*4 +: 4];
        w_g = r_a[k-1][g*4 +: 4] & r_b[k-1][g*4 +: 4];
        w_gc[1] = w_g[0] | (w_p[0] & w_cy);
        w_gc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cy);
        w_gc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_cy);
        w_gc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cy);
        w_sum[k][g*4 +: 4] = w_p ^ {w_gc[3:1], w_cy};
`ifdef CLA_ADD_OVF_EN
        w_cmsb = w_gc[3];
`endif
        w_cy = w_gc[4];
      end
      w_c[k] = w_cy;
    end
  end

  // Data only loads behind a valid slot, so idle-cycle operand garbage never reaches sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_c   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
`ifdef CLA_ADD_OVF_EN
      r_ovf <= 1'b0;
`endif
    end else if (w_adv) begin
      r_vld <= {r_vld[STAGES-1:0], bus.in_valid};
      if (bus.in_valid) begin
        r_a[0] <= bus.a;
        r_b[0] <= bus.b ^ {WIDTH{bus.sub}};
        r_c[0] <= bus.cin | bus.sub;
      end
      for (int k = 1; k <= STAGES; k++) begin
        if (r_vld[k-1]) begin
          r_sum[k] <= w_sum[k];
          r_c[k]   <= w_c[k];
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (r_vld[k-1]) begin
          r_a[k] <= r_a[k-1];
          r_b[k] <= r_b[k-1];
        end
      end
`ifdef CLA_ADD_OVF_EN
      if (r_vld[STAGES-1]) r_ovf <= w_c[STAGES] ^ w_cmsb;
`endif
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[STAGES];
  assign bus.sum       = r_sum[STAGES];
  assign bus.cout      = r_c[STAGES];
`ifdef CLA_ADD_OVF_EN
  assign bus.ovf       = r_ovf;
`endif
endmodule
